rv_multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences the ALU unit, the register file, PC and IR registers, and the single shared memory port.
- Fetches each instruction, decodes the opcode, and drives alu_op / addr_alu_op / funct3 to the ALU unit.
- Steers writeback and memory access, and halts on an illegal opcode or ALU fault.
- Holds no datapath values; all data lives in the PC, IR and register file.

---
 rtl/rv_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences fetch, decode, execute, memory access and PC update for the
// instruction held in IR. Holds no datapath values: every output is decoded
// from the current state, the IR opcode and the handshake/fault inputs.
module rv_multicycle_ctrl #(
    parameter bit RESET_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        branch_taken,
    input  logic        alu_fault,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [2:0]  alu_op,
    output logic [1:0]  addr_alu_op,
    output logic [2:0]  funct3,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_NEXTPC = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] ALU_IMM   = 3'd0;
    localparam logic [2:0] ALU_PC4   = 3'd1;
    localparam logic [2:0] ALU_OPIMM = 3'd5;
    localparam logic [2:0] ALU_OP    = 3'd6;

    localparam logic [1:0] ADDR_PC     = 2'd0;
    localparam logic [1:0] ADDR_PC_IMM = 2'd1;
    localparam logic [1:0] ADDR_RS1_IMM = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_ADDR = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op, is_legal;

    // Only the opcode and funct3 fields matter to the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

    assign opcode    = instr[6:0];
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                       is_load | is_store | is_opimm | is_op;

    assign funct3 = instr[14:12];
    assign state  = state_q;

    // State register; reset restarts at FETCH (or parks in HALT for bring-up).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_HALT ? ST_HALT : ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = is_legal ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                if (is_op || is_opimm) begin
                    state_d = alu_fault ? ST_HALT : ST_NEXTPC;
                end else if (is_lui || is_auipc) begin
                    state_d = ST_NEXTPC;
                end else if (is_jal || is_jalr) begin
                    state_d = ST_FETCH;
                end else if (is_branch) begin
                    state_d = branch_taken ? ST_FETCH : ST_NEXTPC;
                end else if (is_load || is_store) begin
                    state_d = ST_MEM;
                end else begin
                    // IR changed under us; treat as illegal.
                    state_d = ST_HALT;
                end
            end
            ST_MEM: begin
                if (mem_ready) state_d = ST_NEXTPC;
            end
            ST_NEXTPC: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    // Output decode; reset masks every strobe in the same cycle it is seen.
    always_comb begin
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        alu_op       = ALU_PC4;
        addr_alu_op  = ADDR_PC;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        halted       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                if (is_op || is_opimm) begin
                    alu_op = is_op ? ALU_OP : ALU_OPIMM;
                    rf_we  = ~alu_fault;
                end else if (is_lui) begin
                    alu_op = ALU_IMM;
                    rf_we  = 1'b1;
                end else if (is_auipc) begin
                    addr_alu_op = ADDR_PC_IMM;
                    wb_sel      = WB_ADDR;
                    rf_we       = 1'b1;
                end else if (is_jal || is_jalr) begin
                    // Link write and PC update land on the same edge.
                    rf_we       = 1'b1;
                    addr_alu_op = is_jal ? ADDR_PC_IMM : ADDR_RS1_IMM;
                    pc_sel      = 1'b1;
                    pc_we       = 1'b1;
                end else if (is_branch) begin
                    addr_alu_op = ADDR_PC_IMM;
                    pc_sel      = branch_taken;
                    pc_we       = branch_taken;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                addr_alu_op  = ADDR_RS1_IMM;
                mem_we       = is_store;
                if (mem_ready && is_load) begin
                    rf_we  = 1'b1;
                    wb_sel = WB_MEM;
                end
            end
            ST_NEXTPC: begin
                pc_we = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            rf_we   = 1'b0;
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: walks each instruction class through
// the FSM and compares the packed control word against hand-derived values.
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        alu_fault;
    logic        ir_we, pc_we, pc_sel, mem_req, mem_we, mem_addr_sel, rf_we, halted;
    logic [2:0]  alu_op, funct3, state;
    logic [1:0]  addr_alu_op, wb_sel;

    int checks = 0;
    int errors = 0;

    logic [17:0] obs;
    logic [17:0] want;

    rv_multicycle_ctrl #(.RESET_HALT(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .alu_fault    (alu_fault),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .alu_op       (alu_op),
        .addr_alu_op  (addr_alu_op),
        .funct3       (funct3),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .halted       (halted),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {state, ir_we, pc_we, pc_sel, alu_op, addr_alu_op,
                  mem_req, mem_we, mem_addr_sel, rf_we, wb_sel, halted};

    // Packs an expected control word in the same field order as obs.
    function automatic logic [17:0] pk(input logic [2:0] st, input logic irw,
                                       input logic pcw, input logic pcs,
                                       input logic [2:0] aop, input logic [1:0] adop,
                                       input logic mrq, input logic mwe,
                                       input logic mas, input logic rfw,
                                       input logic [1:0] wbs, input logic hlt);
        return {st, irw, pcw, pcs, aop, adop, mrq, mwe, mas, rfw, wbs, hlt};
    endfunction

    // Advance to the next falling edge, apply inputs for the current state, settle.
    task automatic step(input logic rdy, input logic bt, input logic af);
        @(negedge clk);
        mem_ready    = rdy;
        branch_taken = bt;
        alu_fault    = af;
        #1;
    endtask

    // Pulse reset for one edge and leave the FSM parked in FETCH (mem_ready low).
    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        want = pk(3'd0, 0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL reset_strobes got %b want %b", obs, want); end
        rst = 1'b0;
        mem_ready = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd0, 0, 0, 0, 3'd1, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL reset_fetch_wait got %b want %b", obs, want); end
        $display("reset: state=%0d mem_req=%0d", state, mem_req);
    endtask

    task automatic test_addi();
        instr = 32'h00A00093;
        step(1'b1, 1'b0, 1'b0);
        checks++;
        want = pk(3'd0, 1, 0, 0, 3'd1, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL addi_fetch got %b want %b", obs, want); end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        want = pk(3'd1, 0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL addi_decode got %b want %b", obs, want); end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd2, 0, 0, 0, 3'd5, 2'd0, 0, 0, 0, 1, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL addi_exec got %b want %b", obs, want); end
        checks++;
        if (funct3 !== 3'd0) begin errors++; $display("FAIL addi_funct3 got %0d want 0", funct3); end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd4, 0, 1, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL addi_nextpc got %b want %b", obs, want); end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL addi_back_to_fetch got %0d want 0", state); end
        $display("addi: instr=%h done state=%0d", instr, state);
    endtask

    // Runs one instruction through EXEC and compares that cycle's control word.
    task automatic test_exec(input logic [31:0] ins, input logic bt, input logic af,
                             input logic [17:0] exp_exec, input logic [2:0] exp_next,
                             input string name);
        instr = ins;
        step(1'b1, bt, af);
        step(1'b0, bt, af);
        step(1'b0, bt, af);
        checks++;
        if (obs !== exp_exec) begin errors++; $display("FAIL %s_exec got %b want %b", name, obs, exp_exec); end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== exp_next) begin errors++; $display("FAIL %s_after_exec got %0d want %0d", name, state, exp_next); end
        $display("exec %s: instr=%h next_state=%0d", name, ins, state);
        if (state == 3'd4) step(1'b0, 1'b0, 1'b0);
        if (state == 3'd5) do_reset();
    endtask

    task automatic test_load_wait();
        instr = 32'h0000A103;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd2, 0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL load_exec got %b want %b", obs, want); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            want = pk(3'd3, 0, 0, 0, 3'd1, 2'd2, 1, 0, 1, 0, 2'd0, 0);
            if (obs !== want) begin errors++; $display("FAIL load_mem_wait%0d got %b want %b", i, obs, want); end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        want = pk(3'd3, 0, 0, 0, 3'd1, 2'd2, 1, 0, 1, 1, 2'd2, 0);
        if (obs !== want) begin errors++; $display("FAIL load_mem_ready got %b want %b", obs, want); end
        checks++;
        if (funct3 !== 3'd2) begin errors++; $display("FAIL load_funct3 got %0d want 2", funct3); end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd4, 0, 1, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL load_nextpc got %b want %b", obs, want); end
        step(1'b0, 1'b0, 1'b0);
        $display("load_wait: instr=%h state=%0d", instr, state);
    endtask

    // Cycles from FETCH entry back to FETCH with zero-wait memory.
    task automatic test_latency(input logic [31:0] ins, input logic bt, input int exp_n);
        int n;
        instr = ins;
        branch_taken = bt;
        alu_fault = 1'b0;
        mem_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (state !== 3'd0 && n < 20);
        mem_ready = 1'b0;
        checks++;
        if (n !== exp_n) begin errors++; $display("FAIL latency_%h got %0d want %0d", ins, n, exp_n); end
        $display("latency: instr=%h taken=%0d cycles=%0d", ins, bt, n);
    endtask

    task automatic test_fault_halt();
        instr = 32'h002081B3;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        want = pk(3'd2, 0, 0, 0, 3'd6, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL op_fault_exec got %b want %b", obs, want); end
        for (int i = 0; i < 10; i++) begin
            step(logic'(i[0]), 1'b0, 1'b0);
            checks++;
            want = pk(3'd5, 0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 1);
            if (obs !== want) begin errors++; $display("FAIL halt_hold%0d got %b want %b", i, obs, want); end
        end
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd0, 0, 0, 0, 3'd1, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL halt_cleared got %b want %b", obs, want); end
        $display("fault_halt: instr=%h halted=%0d after reset", instr, halted);
    endtask

    task automatic test_illegal();
        instr = 32'h0000007F;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        checks++;
        want = pk(3'd1, 0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL illegal_decode got %b want %b", obs, want); end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        want = pk(3'd5, 0, 0, 0, 3'd1, 2'd0, 0, 0, 0, 0, 2'd0, 1);
        if (obs !== want) begin errors++; $display("FAIL illegal_halt got %b want %b", obs, want); end
        $display("illegal: instr=%h state=%0d", instr, state);
        do_reset();
    endtask

    task automatic test_store_reset();
        instr = 32'h0020A023;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        want = pk(3'd3, 0, 0, 0, 3'd1, 2'd2, 1, 1, 1, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL store_mem got %b want %b", obs, want); end
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        want = pk(3'd3, 0, 0, 0, 3'd1, 2'd2, 0, 0, 1, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL store_rst_mask got %b want %b", obs, want); end
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        want = pk(3'd0, 0, 0, 0, 3'd1, 2'd0, 1, 0, 0, 0, 2'd0, 0);
        if (obs !== want) begin errors++; $display("FAIL store_rst_fetch got %b want %b", obs, want); end
        $display("store_reset: instr=%h state=%0d", instr, state);
    endtask

    initial begin
        rst = 1'b1;
        instr = 32'h00000013;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        alu_fault = 1'b0;
        test_reset();
        test_addi();
        // JAL, JALR, taken/untaken BRANCH, LUI and AUIPC (alu_fault must be ignored).
        test_exec(32'h0000006F, 1'b0, 1'b1, pk(3'd2, 0, 1, 1, 3'd1, 2'd1, 0, 0, 0, 1, 2'd0, 0), 3'd0, "jal");
        test_exec(32'h00008067, 1'b0, 1'b0, pk(3'd2, 0, 1, 1, 3'd1, 2'd2, 0, 0, 0, 1, 2'd0, 0), 3'd0, "jalr");
        test_exec(32'h00208463, 1'b1, 1'b0, pk(3'd2, 0, 1, 1, 3'd1, 2'd1, 0, 0, 0, 0, 2'd0, 0), 3'd0, "br_taken");
        test_exec(32'h00208463, 1'b0, 1'b0, pk(3'd2, 0, 0, 0, 3'd1, 2'd1, 0, 0, 0, 0, 2'd0, 0), 3'd4, "br_not");
        test_exec(32'h000000B7, 1'b0, 1'b1, pk(3'd2, 0, 0, 0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0, 0), 3'd4, "lui");
        test_exec(32'h00000097, 1'b0, 1'b1, pk(3'd2, 0, 0, 0, 3'd1, 2'd1, 0, 0, 0, 1, 2'd1, 0), 3'd4, "auipc");
        test_load_wait();
        test_latency(32'h00A00093, 1'b0, 4);
        test_latency(32'h002081B3, 1'b0, 4);
        test_latency(32'h000000B7, 1'b0, 4);
        test_latency(32'h0000006F, 1'b0, 3);
        test_latency(32'h00208463, 1'b1, 3);
        test_latency(32'h00208463, 1'b0, 4);
        test_latency(32'h0000A103, 1'b0, 5);
        test_latency(32'h0020A023, 1'b0, 5);
        test_fault_halt();
        test_illegal();
        test_store_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
